// File: rtl/merge_unit_ctrl.sv
// One 2-to-1 node of a merge-sort tree: merges paired sorted runs from two FWFT FIFOs
// into a single zero-terminated run per pair on the downstream FIFO.
module merge_unit_ctrl #(
    parameter int DATA_W    = 32,
    parameter int KEY_W     = 32,
    parameter int RUN_W     = 16,
    parameter bit ASCENDING = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [RUN_W-1:0]  i_num_runs,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_empty,
    output logic              o_a_rd,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_empty,
    output logic              o_b_rd,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_wr,
    input  logic              i_out_full,
    output logic [RUN_W-1:0]  o_runs_left,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MERGE,
        S_DRAIN_A,
        S_DRAIN_B,
        S_TERM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_wr_q, out_wr_d;
    logic [RUN_W-1:0]  runs_left_q, runs_left_d;

    logic [KEY_W-1:0]  key_a, key_b;
    logic              a_term, b_term, a_wins, go, idle_like;
    logic              pop_a, pop_b, wr_en;
    logic [DATA_W-1:0] wr_data;

    assign key_a     = i_a_data[DATA_W-1 -: KEY_W];
    assign key_b     = i_b_data[DATA_W-1 -: KEY_W];
    assign a_term    = (key_a == '0);
    assign b_term    = (key_b == '0);
    // Ties resolve to A in both directions so equal keys keep their upstream order.
    assign a_wins    = ASCENDING ? (key_a <= key_b) : (key_a >= key_b);
    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);

    // i_out_full is almost-full: one slot remains for the write already in flight.
    always_comb begin
        go = 1'b0;
        case (state_q)
            S_MERGE:   go = ~i_out_full & ~i_a_empty & ~i_b_empty;
            S_DRAIN_A: go = ~i_out_full & ~i_a_empty;
            S_DRAIN_B: go = ~i_out_full & ~i_b_empty;
            S_TERM:    go = ~i_out_full;
            default:   go = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d = (i_num_runs == '0) ? S_DONE : S_MERGE;
                end
            end
            S_MERGE: begin
                if (go) begin
                    if (a_term && b_term) begin
                        state_d = S_TERM;
                    end else if (a_term) begin
                        state_d = S_DRAIN_B;
                    end else if (b_term) begin
                        state_d = S_DRAIN_A;
                    end
                end
            end
            S_DRAIN_A: begin
                if (go && a_term) begin
                    state_d = S_TERM;
                end
            end
            S_DRAIN_B: begin
                if (go && b_term) begin
                    state_d = S_TERM;
                end
            end
            S_TERM: begin
                if (go) begin
                    state_d = (runs_left_q == RUN_W'(1)) ? S_DONE : S_MERGE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: pops and the record to be registered
    always_comb begin
        pop_a   = 1'b0;
        pop_b   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        case (state_q)
            S_MERGE: begin
                if (go) begin
                    if (a_term || b_term) begin
                        pop_a = a_term;
                        pop_b = b_term;
                    end else if (a_wins) begin
                        pop_a   = 1'b1;
                        wr_en   = 1'b1;
                        wr_data = i_a_data;
                    end else begin
                        pop_b   = 1'b1;
                        wr_en   = 1'b1;
                        wr_data = i_b_data;
                    end
                end
            end
            S_DRAIN_A: begin
                if (go) begin
                    pop_a   = 1'b1;
                    wr_en   = ~a_term;
                    wr_data = i_a_data;
                end
            end
            S_DRAIN_B: begin
                if (go) begin
                    pop_b   = 1'b1;
                    wr_en   = ~b_term;
                    wr_data = i_b_data;
                end
            end
            S_TERM: begin
                wr_en = go;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_wr_d    = wr_en;
        out_data_d  = wr_en ? wr_data : out_data_q;
        runs_left_d = runs_left_q;
        if (idle_like && i_start) begin
            runs_left_d = i_num_runs;
        end else if ((state_q == S_TERM) && go) begin
            runs_left_d = runs_left_q - RUN_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_wr_q    <= 1'b0;
            out_data_q  <= '0;
            runs_left_q <= '0;
        end else begin
            out_wr_q    <= out_wr_d;
            out_data_q  <= out_data_d;
            runs_left_q <= runs_left_d;
        end
    end

    // Pops are suppressed while reset is held so an abandoned run consumes nothing more.
    assign o_a_rd      = pop_a & ~i_rst;
    assign o_b_rd      = pop_b & ~i_rst;
    assign o_out_wr    = out_wr_q;
    assign o_out_data  = out_data_q;
    assign o_runs_left = runs_left_q;
    assign o_busy      = (state_q == S_MERGE) || (state_q == S_DRAIN_A) ||
                         (state_q == S_DRAIN_B) || (state_q == S_TERM);
    assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_merge_unit_ctrl.sv
// Bench for merge_unit_ctrl: directed cases and randomised runs on an ascending and a
// descending instance, checked against a stable-sort reference of each run pair.
module tb_merge_unit_ctrl;

    localparam int DW = 16;
    localparam int KW = 8;
    localparam int RW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           start;
    logic [1:0][RW-1:0]   num_runs;
    logic [1:0][DW-1:0]   a_data;
    logic [1:0]           a_empty;
    logic [1:0]           a_rd;
    logic [1:0][DW-1:0]   b_data;
    logic [1:0]           b_empty;
    logic [1:0]           b_rd;
    logic [1:0][DW-1:0]   out_data;
    logic [1:0]           out_wr;
    logic [1:0]           out_full;
    logic [1:0][RW-1:0]   runs_left;
    logic [1:0]           busy;
    logic [1:0]           done;

    // Instance 0 merges ascending, instance 1 descending.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            merge_unit_ctrl #(
                .DATA_W(DW), .KEY_W(KW), .RUN_W(RW), .ASCENDING(gi == 0)
            ) u_dut (
                .i_clk(clk),
                .i_rst(rst),
                .i_start(start[gi]),
                .i_num_runs(num_runs[gi]),
                .i_a_data(a_data[gi]),
                .i_a_empty(a_empty[gi]),
                .o_a_rd(a_rd[gi]),
                .i_b_data(b_data[gi]),
                .i_b_empty(b_empty[gi]),
                .o_b_rd(b_rd[gi]),
                .o_out_data(out_data[gi]),
                .o_out_wr(out_wr[gi]),
                .i_out_full(out_full[gi]),
                .o_runs_left(runs_left[gi]),
                .o_busy(busy[gi]),
                .o_done(done[gi])
            );
        end
    endgenerate

    logic [DW-1:0] qa[$], qb[$], got[$], a_src[$], b_src[$];
    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int hold_full = 0;
    int hold_b = 0;
    logic last_a_rd, last_b_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [DW-1:0] rec(input int k, input int p);
        return {k[KW-1:0], p[DW-KW-1:0]};
    endfunction

    function automatic logic [KW-1:0] key_of(input logic [DW-1:0] r);
        return r[DW-1 -: KW];
    endfunction

    // Merging two sorted runs with ties to A equals a stable sort of A's run followed by B's.
    function automatic void model(input logic [DW-1:0] a_in[$], input logic [DW-1:0] b_in[$],
                                  input int nruns, input bit asc, output logic [DW-1:0] res[$]);
        int ia = 0;
        int ib = 0;
        res = {};
        for (int r = 0; r < nruns; r++) begin
            logic [DW-1:0] run[$];
            run = {};
            while (ia < a_in.size() && key_of(a_in[ia]) != 0) begin
                run.push_back(a_in[ia]);
                ia++;
            end
            ia++;
            while (ib < b_in.size() && key_of(b_in[ib]) != 0) begin
                run.push_back(b_in[ib]);
                ib++;
            end
            ib++;
            for (int i = 1; i < run.size(); i++) begin
                for (int j = i; j > 0; j--) begin
                    logic [DW-1:0] tmp;
                    if (asc ? (key_of(run[j]) < key_of(run[j-1]))
                            : (key_of(run[j]) > key_of(run[j-1]))) begin
                        tmp      = run[j];
                        run[j]   = run[j-1];
                        run[j-1] = tmp;
                    end
                end
            end
            foreach (run[i]) res.push_back(run[i]);
            res.push_back('0);
        end
    endfunction

    task automatic add_run(input bit asc, input bit to_a);
        int keys[$];
        int len;
        len = int'($urandom_range(0, 5));
        for (int i = 0; i < len; i++) keys.push_back(int'($urandom_range(1, 255)));
        if (asc) keys.sort();
        else keys.rsort();
        foreach (keys[i]) begin
            if (to_a) a_src.push_back(rec(keys[i], int'($urandom_range(0, 255))));
            else b_src.push_back(rec(keys[i], int'($urandom_range(0, 255))));
        end
        if (to_a) a_src.push_back('0);
        else b_src.push_back('0);
    endtask

    // One clock cycle on instance s: drive FIFO heads, observe pops, apply them, sample outputs.
    task automatic cycle(input int s, input int full_pct, input int empty_pct);
        logic ea, eb, ff, ra, rb;
        bit   forced_b;
        forced_b = (hold_b > 0);
        ea = (qa.size() == 0) || (int'($urandom_range(0, 99)) < empty_pct);
        eb = forced_b || (qb.size() == 0) || (int'($urandom_range(0, 99)) < empty_pct);
        ff = (hold_full > 0) || (int'($urandom_range(0, 99)) < full_pct);
        if (hold_b > 0) hold_b--;
        if (hold_full > 0) hold_full--;
        a_data[s]   = (qa.size() != 0) ? qa[0] : DW'($urandom);
        b_data[s]   = (qb.size() != 0) ? qb[0] : DW'($urandom);
        a_empty[s]  = ea;
        b_empty[s]  = eb;
        out_full[s] = ff;
        #1;
        ra = a_rd[s];
        rb = b_rd[s];
        last_a_rd = ra;
        last_b_rd = rb;
        if (ra) check("pop_a_while_empty", ea, 0);
        if (rb) check("pop_b_while_empty", eb, 0);
        if (ff) begin
            check("pop_a_while_full", ra, 0);
            check("pop_b_while_full", rb, 0);
        end
        if (forced_b) check("pop_a_while_b_empty", ra, 0);
        @(posedge clk);
        if (ra && !ea) void'(qa.pop_front());
        if (rb && !eb) void'(qb.pop_front());
        #1;
        cyc++;
        if (ff) check("write_after_full", out_wr[s], 0);
        if (out_wr[s]) got.push_back(out_data[s]);
        @(negedge clk);
    endtask

    task automatic run_case(input int s, input string name, input int n, input int full_pct,
                            input int empty_pct, input int exp_first, input int exp_done,
                            input int full_at);
        logic [DW-1:0] expq[$];
        logic [DW-1:0] g;
        int t0, first, budget;
        qa  = a_src;
        qb  = b_src;
        got = {};
        first = -1;
        model(a_src, b_src, n, (s == 0), expq);
        t0 = cyc;
        start[s]    = 1'b1;
        num_runs[s] = RW'(n);
        cycle(s, full_pct, empty_pct);
        start[s] = 1'b0;
        if (got.size() > 0 && first < 0) first = cyc - t0;
        budget = 0;
        while (!done[s] && budget < 3000) begin
            if (budget == full_at) hold_full = 3;
            cycle(s, full_pct, empty_pct);
            budget++;
            if (got.size() > 0 && first < 0) first = cyc - t0;
            if (done[s] && n > 0) check({name, "_done_with_last_write"},
                                        {out_wr[s], out_data[s]}, {1'b1, {DW{1'b0}}});
        end
        check({name, "_done"}, done[s], 1);
        if (exp_first >= 0) check({name, "_first_write_latency"}, first, exp_first);
        if (exp_done >= 0) check({name, "_done_latency"}, cyc - t0, exp_done);
        check({name, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            g = (i < got.size()) ? got[i] : 'x;
            check({name, "_record"}, g, expq[i]);
        end
        check({name, "_runs_left"}, runs_left[s], 0);
        check({name, "_busy"}, busy[s], 0);
        check({name, "_fifos_consumed"}, qa.size() + qb.size(), 0);
        cycle(s, 0, 0);
        check({name, "_done_held"}, {done[s], out_wr[s]}, 2'b10);
        $display("case %s: %0d records written, %0d expected, %0d cycles",
                 name, got.size(), expq.size(), cyc - t0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = '0;
        num_runs  = '0;
        a_data    = '0;
        b_data    = '0;
        a_empty   = 2'b11;
        b_empty   = 2'b11;
        out_full  = '0;
        @(negedge clk);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int s = 0; s < 2; s++) begin
            check("reset_out_wr", out_wr[s], 0);
            check("reset_out_data", out_data[s], 0);
            check("reset_runs_left", runs_left[s], 0);
            check("reset_done", done[s], 0);
            check("reset_busy", busy[s], 0);
        end
        rst = 1'b0;
        cycle(0, 0, 0);

        a_src = {}; b_src = {};
        run_case(1, "zero_runs", 0, 0, 0, -1, 1, -1);

        a_src = {rec(3, 1), rec(7, 2), 16'h0};
        b_src = {rec(5, 3), rec(6, 4), 16'h0};
        run_case(0, "basic_asc", 1, 0, 0, 2, 8, -1);

        a_src = {rec(4, 1), 16'h0};
        b_src = {rec(4, 2), 16'h0};
        run_case(0, "tie_asc", 1, 0, 0, 2, -1, -1);

        a_src = {rec(9, 1), rec(2, 2), 16'h0};
        b_src = {rec(5, 3), rec(1, 4), 16'h0};
        run_case(1, "basic_desc", 1, 0, 0, 2, -1, -1);

        a_src = {rec(4, 7), 16'h0};
        b_src = {rec(4, 8), 16'h0};
        run_case(1, "tie_desc", 1, 0, 0, 2, -1, -1);

        a_src = {16'h0};
        b_src = {rec(2, 1), rec(9, 2), 16'h0};
        run_case(0, "a_term_first", 1, 0, 0, -1, -1, -1);

        a_src = {rec(5, 1), 16'h0};
        b_src = {rec(6, 2), 16'h0};
        run_case(0, "a_term_in_merge", 1, 0, 0, -1, -1, -1);

        a_src = {16'h0};
        b_src = {16'h0};
        run_case(0, "both_term", 1, 0, 0, 3, 3, -1);

        a_src = {rec(3, 1), rec(7, 2), 16'h0};
        b_src = {rec(5, 3), rec(6, 4), 16'h0};
        run_case(0, "full_hold", 1, 0, 0, -1, 11, 1);

        a_src = {rec(3, 1), rec(7, 2), 16'h0};
        b_src = {rec(5, 3), rec(6, 4), 16'h0};
        hold_b = 4;
        run_case(0, "b_empty_hold", 1, 0, 0, -1, 11, -1);

        a_src = {rec(1, 1), 16'h0, rec(8, 2), 16'h0};
        b_src = {rec(2, 3), 16'h0, 16'h0};
        run_case(0, "multi_run", 2, 0, 0, -1, -1, -1);

        // Reset while draining A, then a normal run afterwards.
        a_src = {rec(1, 1), rec(2, 2), rec(3, 3), rec(4, 4), rec(5, 5), rec(6, 6), 16'h0};
        b_src = {16'h0};
        qa = a_src; qb = b_src; got = {};
        start[0] = 1'b1; num_runs[0] = RW'(1);
        cycle(0, 0, 0);
        start[0] = 1'b0;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("mid_run_busy", busy[0], 1);
        check("mid_run_runs_left", runs_left[0], 1);
        rst = 1'b1;
        cycle(0, 0, 0);
        check("rst_mid_out_wr", out_wr[0], 0);
        check("rst_mid_busy", busy[0], 0);
        check("rst_mid_runs_left", runs_left[0], 0);
        check("rst_mid_done", done[0], 0);
        rst = 1'b0;
        cycle(0, 0, 0);
        check("after_rst_a_rd", last_a_rd, 0);
        check("after_rst_b_rd", last_b_rd, 0);
        check("after_rst_out_wr", out_wr[0], 0);
        $display("case reset_mid_run: reset applied during drain");

        a_src = {rec(3, 1), rec(7, 2), 16'h0};
        b_src = {rec(5, 3), rec(6, 4), 16'h0};
        run_case(0, "after_reset", 1, 0, 0, 2, 8, -1);

        for (int k = 0; k < 16; k++) begin
            int s;
            int n;
            s = k % 2;
            n = int'($urandom_range(1, 4));
            a_src = {}; b_src = {};
            for (int r = 0; r < n; r++) begin
                add_run(s == 0, 1'b1);
                add_run(s == 0, 1'b0);
            end
            run_case(s, (s == 0) ? "random_asc" : "random_desc", n,
                     int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), -1, -1, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
